// File: rtl/ebus_pkg.sv
// ---------------------------------------------------------------------------
// ebus_pkg
// Shared EBUS definitions used by the responder, its interface and the PI
// request sub-module.
//   ebus_cs_t     7-bit controller-select code
//   ebus_word_t   36-bit EBUS word, PDP-10 bit order (bit 0 = MSB, 35 = LSB)
//   ebus_func_t   EBUS_F function codes
//   ebus_state_t  responder transfer FSM states
// ---------------------------------------------------------------------------
package ebus_pkg;

  typedef logic [6:0]  ebus_cs_t;
  typedef logic [0:35] ebus_word_t;

  typedef enum logic [2:0] {
    F_CONO  = 3'b000,
    F_CONI  = 3'b001,
    F_DATAO = 3'b010,
    F_DATAI = 3'b011
  } ebus_func_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_XFER      = 3'd3,
    ST_SKIP      = 3'd4
  } ebus_state_t;

  // Master-to-device functions: the device captures a word.
  function automatic logic is_write_f(input logic [2:0] f);
    return (f == F_CONO) || (f == F_DATAO);
  endfunction

  // Device-to-master functions: the responder drives EBUS_DATA_OUT.
  function automatic logic is_read_f(input logic [2:0] f);
    return (f == F_CONI) || (f == F_DATAI);
  endfunction

endpackage

// File: rtl/ebus_if.sv
// ---------------------------------------------------------------------------
// ebus_if
// EBUS transfer signals between the APR/CON master and a device responder.
//   EBUS_CS / EBUS_F / EBUS_DEMAND / EBUS_DATA_IN   master -> device
//   EBUS_XFER / EBUS_DATA_OUT / EBUS_DATA_OE / EBUS_PI device -> master
// Modports: master (EBOX side), slave (device responder side).
// ---------------------------------------------------------------------------
interface ebus_if;
  import ebus_pkg::*;

  ebus_cs_t   EBUS_CS;
  logic [2:0] EBUS_F;
  logic       EBUS_DEMAND;
  ebus_word_t EBUS_DATA_IN;
  logic       EBUS_XFER;
  ebus_word_t EBUS_DATA_OUT;
  logic       EBUS_DATA_OE;
  logic [1:7] EBUS_PI;

  modport master (
    output EBUS_CS, EBUS_F, EBUS_DEMAND, EBUS_DATA_IN,
    input  EBUS_XFER, EBUS_DATA_OUT, EBUS_DATA_OE, EBUS_PI
  );

  modport slave (
    input  EBUS_CS, EBUS_F, EBUS_DEMAND, EBUS_DATA_IN,
    output EBUS_XFER, EBUS_DATA_OUT, EBUS_DATA_OE, EBUS_PI
  );

endinterface

// File: rtl/ebus_pi_req.sv
// ---------------------------------------------------------------------------
// ebus_pi_req
// Holds the device PI assignment and turns DEV_INT into a registered one-hot
// PI request on the assigned level (level 0 means "no PI").
//   clk, RESET_n   clock, synchronous active-low reset
//   pia_load       load pia_in into the PIA register (CONO)
//   pia_in [0:2]   new PI assignment
//   dev_int        device interrupt condition
//   pia    [0:2]   current PI assignment
//   pi     [1:7]   one-hot PI request, one cycle behind dev_int / pia
// ---------------------------------------------------------------------------
module ebus_pi_req (
  input  logic       clk,
  input  logic       RESET_n,
  input  logic       pia_load,
  input  logic [0:2] pia_in,
  input  logic       dev_int,
  output logic [0:2] pia,
  output logic [1:7] pi
);

  logic [0:2] pia_q, pia_d;
  logic [1:7] pi_q, pi_d;

  always_comb begin
    pia_d = pia_q;
    if (pia_load) begin
      pia_d = pia_in;
    end
  end

  // Request line k is driven from the registered PIA, so a new assignment
  // reaches EBUS_PI one cycle after PIA itself changes.
  for (genvar gi = 1; gi <= 7; gi++) begin : g_pi
    assign pi_d[gi] = dev_int && (pia_q == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      pia_q <= '0;
      pi_q  <= '0;
    end else begin
      pia_q <= pia_d;
      pi_q  <= pi_d;
    end
  end

  assign pia = pia_q;
  assign pi  = pi_q;

endmodule

// File: rtl/ebus_responder.sv
// ---------------------------------------------------------------------------
// ebus_responder
// Device-side EBUS slave: decodes controller select and function, runs the
// DEMAND/XFER handshake, captures CONO/DATAO words and returns CONI/DATAI
// words. Owns the PI assignment through ebus_pi_req.
// Parameters: DEV_CS (select code answered), WAIT_MAX (DATAI wait limit).
// Ports:
//   clk, RESET_n              clock, synchronous active-low reset
//   bus (ebus_if.slave)       EBUS transfer signals
//   CONI_STATUS [0:35]        live status, bits 33:35 replaced by PIA
//   DATAI_WORD, DATAI_VALID   device read word and its ready flag
//   DEV_INT                   device interrupt condition
//   CONO_WR, DATAO_WR         one-cycle write strobes, word on WR_DATA
//   WR_DATA [0:35]            last captured write word
//   DATAI_ACK                 one-cycle pulse, DATAI_WORD consumed
//   PIA [0:2]                 current PI assignment
// ---------------------------------------------------------------------------
module ebus_responder
  import ebus_pkg::*;
#(
  parameter ebus_cs_t DEV_CS   = 7'o00,
  parameter int       WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        RESET_n,
  ebus_if.slave       bus,
  input  ebus_word_t  CONI_STATUS,
  input  ebus_word_t  DATAI_WORD,
  input  logic        DATAI_VALID,
  input  logic        DEV_INT,
  output logic        CONO_WR,
  output logic        DATAO_WR,
  output ebus_word_t  WR_DATA,
  output logic        DATAI_ACK,
  output logic [0:2]  PIA
);

  localparam int            CW        = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  ebus_state_t   state_q, state_d;
  ebus_cs_t      cs_q, cs_d;
  logic [2:0]    f_q, f_d;
  ebus_word_t    wr_data_q, wr_data_d;
  ebus_word_t    rd_q, rd_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          cono_wr, datao_wr, datai_ack;
  logic          xfer, data_oe;
  logic [0:2]    pia;
  logic [1:7]    pi;
  ebus_word_t    coni_word;

  assign coni_word = {CONI_STATUS[0:32], pia};

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    f_d        = f_q;
    wr_data_d  = wr_data_q;
    rd_d       = rd_q;
    wait_cnt_d = wait_cnt_q;
    cono_wr    = 1'b0;
    datao_wr   = 1'b0;
    datai_ack  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.EBUS_DEMAND) begin
          cs_d    = bus.EBUS_CS;
          f_d     = bus.EBUS_F;
          // The write word is taken straight off the bus here so WR_DATA is
          // already valid when the strobe fires in DECODE, and a transfer
          // addressed elsewhere never disturbs it.
          if (bus.EBUS_CS == DEV_CS && is_write_f(bus.EBUS_F)) begin
            wr_data_d = bus.EBUS_DATA_IN;
          end
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        wait_cnt_d = '0;
        if (cs_q != DEV_CS || !(is_write_f(f_q) || is_read_f(f_q))) begin
          state_d = ST_SKIP;
        end else begin
          case (f_q)
            F_CONO: begin
              cono_wr = 1'b1;
              state_d = ST_XFER;
            end
            F_DATAO: begin
              datao_wr = 1'b1;
              state_d  = ST_XFER;
            end
            F_CONI: begin
              rd_d    = coni_word;
              state_d = ST_XFER;
            end
            default: begin  // F_DATAI
              if (DATAI_VALID) begin
                rd_d      = DATAI_WORD;
                datai_ack = 1'b1;
                state_d   = ST_XFER;
              end else begin
                state_d = ST_WAIT_DATA;
              end
            end
          endcase
        end
      end

      ST_WAIT_DATA: begin
        // Data arriving wins over a simultaneous DEMAND drop or timeout.
        if (DATAI_VALID) begin
          rd_d      = DATAI_WORD;
          datai_ack = 1'b1;
          state_d   = ST_XFER;
        end else if (!bus.EBUS_DEMAND) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Give up silently; the master's own timeout handles the rest.
          state_d = ST_SKIP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_XFER, ST_SKIP: begin
        // SKIP waits out the DEMAND so a CS change mid-DEMAND is not matched.
        if (!bus.EBUS_DEMAND) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      cs_q       <= '0;
      f_q        <= '0;
      wr_data_q  <= '0;
      rd_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      f_q        <= f_d;
      wr_data_q  <= wr_data_d;
      rd_q       <= rd_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  ebus_pi_req u_pi_req (
    .clk      (clk),
    .RESET_n  (RESET_n),
    .pia_load (cono_wr & RESET_n),
    .pia_in   (wr_data_q[33:35]),
    .dev_int  (DEV_INT),
    .pia      (pia),
    .pi       (pi)
  );

  assign xfer    = (state_q == ST_XFER);
  assign data_oe = xfer && is_read_f(f_q);

  assign bus.EBUS_XFER     = xfer;
  assign bus.EBUS_DATA_OE  = data_oe;
  assign bus.EBUS_DATA_OUT = data_oe ? rd_q : '0;
  assign bus.EBUS_PI       = pi;

  // Strobes are combinational from DECODE/WAIT_DATA; reset masks them so a
  // reset landing in that cycle cannot leak a write or ack to the device.
  assign CONO_WR   = cono_wr & RESET_n;
  assign DATAO_WR  = datao_wr & RESET_n;
  assign DATAI_ACK = datai_ack & RESET_n;
  assign WR_DATA   = wr_data_q;
  assign PIA       = pia;

endmodule

// File: tb/tb_ebus_responder.sv
// ---------------------------------------------------------------------------
// tb_ebus_responder
// Directed-vector bench for ebus_responder (DEV_CS=7'o12, WAIT_MAX=4).
// Cycle 0 is the edge where DEMAND is first sampled high; after start()
// returns, the bench sits in cycle 1 (DECODE).
// ---------------------------------------------------------------------------
module tb_ebus_responder;
  import ebus_pkg::*;

  localparam ebus_cs_t DEV = 7'o12;

  logic       clk = 1'b0;
  logic       RESET_n;
  ebus_word_t CONI_STATUS, DATAI_WORD, WR_DATA;
  logic       DATAI_VALID, DEV_INT;
  logic       CONO_WR, DATAO_WR, DATAI_ACK;
  logic [0:2] PIA;

  always #5 clk = ~clk;

  ebus_if bus ();

  ebus_responder #(.DEV_CS(DEV), .WAIT_MAX(4)) dut (
    .clk         (clk),
    .RESET_n     (RESET_n),
    .bus         (bus),
    .CONI_STATUS (CONI_STATUS),
    .DATAI_WORD  (DATAI_WORD),
    .DATAI_VALID (DATAI_VALID),
    .DEV_INT     (DEV_INT),
    .CONO_WR     (CONO_WR),
    .DATAO_WR    (DATAO_WR),
    .WR_DATA     (WR_DATA),
    .DATAI_ACK   (DATAI_ACK),
    .PIA         (PIA)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic xs, ss;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input ebus_cs_t cs, input logic [2:0] f, input ebus_word_t d);
    bus.EBUS_CS      = cs;
    bus.EBUS_F       = f;
    bus.EBUS_DATA_IN = d;
    bus.EBUS_DEMAND  = 1'b1;
    step();
  endtask

  task automatic end_demand();
    bus.EBUS_DEMAND = 1'b0;
    step();
  endtask

  task automatic watch(input int n, output logic xfer_seen, output logic strobe_seen);
    xfer_seen   = 1'b0;
    strobe_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      xfer_seen   = xfer_seen | bus.EBUS_XFER;
      strobe_seen = strobe_seen | CONO_WR | DATAO_WR | DATAI_ACK;
      step();
    end
  endtask

  initial begin
    RESET_n = 1'b0;
    bus.EBUS_CS = '0; bus.EBUS_F = '0; bus.EBUS_DEMAND = 1'b0; bus.EBUS_DATA_IN = '0;
    CONI_STATUS = '0; DATAI_WORD = '0; DATAI_VALID = 1'b0; DEV_INT = 1'b0;
    step(); step();
    RESET_n = 1'b1;

    // Reset state
    check_val("rst_xfer", bus.EBUS_XFER, 0);
    check_val("rst_oe", bus.EBUS_DATA_OE, 0);
    check_val("rst_dout", bus.EBUS_DATA_OUT, 0);
    check_val("rst_pi", bus.EBUS_PI, 0);
    check_val("rst_pia", PIA, 0);
    check_val("rst_wrdata", WR_DATA, 0);
    check_val("rst_strobes", CONO_WR | DATAO_WR | DATAI_ACK, 0);
    $display("txn reset");

    // CONO PIA=5 with DEV_INT=1
    DEV_INT = 1'b1;
    start(DEV, 3'b000, 36'o777000000005);
    check_val("cono_c1_wr", CONO_WR, 1);
    check_val("cono_c1_wrdata", WR_DATA, 36'o777000000005);
    check_val("cono_c1_xfer", bus.EBUS_XFER, 0);
    step();
    check_val("cono_c2_wr", CONO_WR, 0);
    check_val("cono_c2_xfer", bus.EBUS_XFER, 1);
    check_val("cono_c2_oe", bus.EBUS_DATA_OE, 0);
    check_val("cono_c2_pia", PIA, 5);
    check_val("cono_c2_pi", bus.EBUS_PI, 0);
    step();
    check_val("cono_c3_pi", bus.EBUS_PI, 7'b0000100);
    check_val("cono_c3_xfer", bus.EBUS_XFER, 1);
    end_demand();
    check_val("cono_end_xfer", bus.EBUS_XFER, 0);
    $display("txn CONO pia=5");

    // CONO PIA=3 then CONI
    start(DEV, 3'b000, 36'o3);
    step();
    end_demand();
    check_val("pia3", PIA, 3);
    check_val("pi3", bus.EBUS_PI, 7'b0010000);
    CONI_STATUS = 36'o123456701234;
    start(DEV, 3'b001, 36'o0);
    check_val("coni_c1_oe", bus.EBUS_DATA_OE, 0);
    check_val("coni_c1_dout", bus.EBUS_DATA_OUT, 0);
    step();
    check_val("coni_c2_oe", bus.EBUS_DATA_OE, 1);
    check_val("coni_c2_xfer", bus.EBUS_XFER, 1);
    check_val("coni_c2_dout", bus.EBUS_DATA_OUT, 36'o123456701233);
    check_val("coni_wrdata_hold", WR_DATA, 36'o3);
    end_demand();
    check_val("coni_end_oe", bus.EBUS_DATA_OE, 0);
    check_val("coni_end_dout", bus.EBUS_DATA_OUT, 0);
    check_val("coni_end_xfer", bus.EBUS_XFER, 0);
    $display("txn CONI");

    // PI lag on DEV_INT falling
    DEV_INT = 1'b0;
    #1;
    check_val("pi_lag_hold", bus.EBUS_PI, 7'b0010000);
    step();
    check_val("pi_lag_clear", bus.EBUS_PI, 0);
    $display("txn PI lag");

    // DATAI, VALID rises in cycle 4
    DATAI_WORD = 36'o555555555555;
    start(DEV, 3'b011, 36'o0);
    check_val("dwait_c1_ack", DATAI_ACK, 0);
    step(); step(); step();
    DATAI_VALID = 1'b1;
    #1;
    check_val("dwait_c4_ack", DATAI_ACK, 1);
    check_val("dwait_c4_xfer", bus.EBUS_XFER, 0);
    step();
    check_val("dwait_c5_xfer", bus.EBUS_XFER, 1);
    check_val("dwait_c5_ack", DATAI_ACK, 0);
    check_val("dwait_c5_dout", bus.EBUS_DATA_OUT, 36'o555555555555);
    DATAI_VALID = 1'b0;
    end_demand();
    $display("txn DATAI wait");

    // DATAI, VALID in the last wait cycle (cycle 5)
    DATAI_WORD = 36'o000000000777;
    start(DEV, 3'b011, 36'o0);
    step(); step(); step(); step();
    DATAI_VALID = 1'b1;
    #1;
    check_val("dlast_c5_ack", DATAI_ACK, 1);
    step();
    check_val("dlast_c6_xfer", bus.EBUS_XFER, 1);
    check_val("dlast_c6_dout", bus.EBUS_DATA_OUT, 36'o000000000777);
    DATAI_VALID = 1'b0;
    end_demand();
    $display("txn DATAI last-cycle");

    // DATAI timeout: VALID only after the wait window has expired
    start(DEV, 3'b011, 36'o0);
    watch(5, xs, ss);
    check_val("dto_wait_xfer", xs, 0);
    check_val("dto_wait_strobe", ss, 0);
    DATAI_VALID = 1'b1;
    #1;
    check_val("dto_skip_ack", DATAI_ACK, 0);
    watch(4, xs, ss);
    check_val("dto_skip_xfer", xs, 0);
    check_val("dto_skip_strobe", ss, 0);
    DATAI_VALID = 1'b0;
    end_demand();
    check_val("dto_end_xfer", bus.EBUS_XFER, 0);
    $display("txn DATAI timeout");

    // DATAI abort: DEMAND drops while waiting
    start(DEV, 3'b011, 36'o0);
    step();
    end_demand();
    DATAI_VALID = 1'b1;
    #1;
    check_val("dabort_ack", DATAI_ACK, 0);
    check_val("dabort_xfer", bus.EBUS_XFER, 0);
    DATAI_VALID = 1'b0;
    step();
    $display("txn DATAI abort");

    // CS mismatch, then CS switches to DEV inside the same DEMAND
    start(7'o13, 3'b010, 36'o7777);
    bus.EBUS_CS = DEV;
    watch(6, xs, ss);
    check_val("csm_xfer", xs, 0);
    check_val("csm_strobe", ss, 0);
    check_val("csm_wrdata", WR_DATA, 36'o3);
    end_demand();
    $display("txn CS mismatch");

    // Illegal function code
    start(DEV, 3'b101, 36'o7);
    watch(4, xs, ss);
    check_val("illf_xfer", xs, 0);
    check_val("illf_strobe", ss, 0);
    end_demand();
    $display("txn illegal F");

    // DATAO with DEMAND falling in DECODE
    start(DEV, 3'b010, 36'o246);
    check_val("dfall_c1_wr", DATAO_WR, 1);
    check_val("dfall_c1_wrdata", WR_DATA, 36'o246);
    bus.EBUS_DEMAND = 1'b0;
    step();
    check_val("dfall_c2_xfer", bus.EBUS_XFER, 1);
    check_val("dfall_c2_wr", DATAO_WR, 0);
    step();
    check_val("dfall_c3_xfer", bus.EBUS_XFER, 0);
    $display("txn DATAO demand-fall");

    // Reset during DECODE suppresses the CONO strobe
    start(DEV, 3'b000, 36'o6);
    RESET_n = 1'b0;
    bus.EBUS_DEMAND = 1'b0;
    #1;
    check_val("rdec_cono_wr", CONO_WR, 0);
    step();
    RESET_n = 1'b1;
    check_val("rdec_pia", PIA, 0);
    check_val("rdec_wrdata", WR_DATA, 0);
    $display("txn reset in DECODE");

    // Reset mid-XFER, then a DATAO completes normally
    DEV_INT = 1'b1;
    start(DEV, 3'b000, 36'o5);
    step();
    end_demand();
    start(DEV, 3'b001, 36'o0);
    step();
    check_val("rx_pre_xfer", bus.EBUS_XFER, 1);
    check_val("rx_pre_pi", bus.EBUS_PI, 7'b0000100);
    RESET_n = 1'b0;
    step();
    check_val("rx_xfer", bus.EBUS_XFER, 0);
    check_val("rx_oe", bus.EBUS_DATA_OE, 0);
    check_val("rx_dout", bus.EBUS_DATA_OUT, 0);
    check_val("rx_pia", PIA, 0);
    check_val("rx_pi", bus.EBUS_PI, 0);
    check_val("rx_wrdata", WR_DATA, 0);
    RESET_n = 1'b1;
    end_demand();
    start(DEV, 3'b010, 36'o012345670123);
    check_val("rx_datao_wr", DATAO_WR, 1);
    check_val("rx_datao_wrdata", WR_DATA, 36'o012345670123);
    step();
    check_val("rx_datao_xfer", bus.EBUS_XFER, 1);
    check_val("rx_datao_oe", bus.EBUS_DATA_OE, 0);
    end_demand();
    check_val("rx_datao_end", bus.EBUS_XFER, 0);
    $display("txn reset mid-XFER + DATAO");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
